// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, LSB first.
// Reports unsigned carry (no-borrow on subtract) and signed two's-complement overflow.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_cy;
  logic             r_carry;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_last;
  logic w_sum;
  logic w_cout;

  assign w_accept = (r_state != S_RUN) && i_start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_sum  = r_a[0] ^ r_b[0] ^ r_cy;
  assign w_cout = (r_a[0] & r_b[0]) | (r_cy & (r_a[0] ^ r_b[0]));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = i_start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at load and the carry FF seeded with 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cy     <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= i_a;
      r_b      <= i_b ^ {WIDTH{i_mode}};
      r_cy     <= i_mode;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_result <= {w_sum, r_result[WIDTH-1:1]};
      r_cy     <= w_cout;
      if (!w_last) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // r_cy here is the carry into the MSB, so overflow is carry-in XOR carry-out.
      if (w_last) begin
        r_carry <= w_cout;
        r_ovf   <= r_cy ^ w_cout;
      end
    end
  end

  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);
  assign o_result   = r_result;
  assign o_carry    = r_carry;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH 8 (directed), 2 (exhaustive) and 16 (boundary + random).
module tb_serial_addsub;

  typedef struct {
    logic [15:0] res;
    logic        cy;
    logic        ov;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dcnt8 = 0;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q16[$];

  logic        s8 = 1'b0, m8 = 1'b0, busy8, done8, c8, v8;
  logic [7:0]  a8 = '0, b8 = '0, r8;
  logic        s2 = 1'b0, m2 = 1'b0, busy2, done2, c2, v2;
  logic [1:0]  a2 = '0, b2 = '0, r2;
  logic        s16 = 1'b0, m16 = 1'b0, busy16, done16, c16, v16;
  logic [15:0] a16 = '0, b16 = '0, r16;

  serial_addsub #(.WIDTH(8)) u_w8 (
    .i_clk(clk), .i_reset(rst), .i_start(s8), .i_mode(m8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(r8), .o_carry(c8), .o_overflow(v8)
  );
  serial_addsub #(.WIDTH(2)) u_w2 (
    .i_clk(clk), .i_reset(rst), .i_start(s2), .i_mode(m2), .i_a(a2), .i_b(b2),
    .o_busy(busy2), .o_done(done2), .o_result(r2), .o_carry(c2), .o_overflow(v2)
  );
  serial_addsub #(.WIDTH(16)) u_w16 (
    .i_clk(clk), .i_reset(rst), .i_start(s16), .i_mode(m16), .i_a(a16), .i_b(b16),
    .o_busy(busy16), .o_done(done16), .o_result(r16), .o_carry(c16), .o_overflow(v16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic cmp(input string nm, input logic [15:0] gr, input logic [15:0] er,
                     input logic gc, input logic ec, input logic go, input logic eo);
    checks++;
    $display("done %s res=%0h cy=%0b ov=%0b", nm, gr, gc, go);
    if (gr !== er || gc !== ec || go !== eo) begin
      errors++;
      $display("FAIL %s got res=%0h cy=%0b ov=%0b expected res=%0h cy=%0b ov=%0b",
               nm, gr, gc, go, er, ec, eo);
    end
  endtask

  // Independent reference: integer arithmetic and signed-range test.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic m, input string nm);
    exp_t   e;
    longint lim, ua, ub, sa, sb, r, s;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    if (m) begin
      r    = ua - ub;
      e.cy = (ua >= ub);
      s    = sa - sb;
    end else begin
      r    = ua + ub;
      e.cy = (r >= lim);
      s    = sa + sb;
    end
    e.res = 16'(r & (lim - 1));
    e.ov  = (s >= lim / 2) || (s < -(lim / 2));
    e.nm  = nm;
    return e;
  endfunction

  // Monitors: pop the scoreboard whenever a DUT pulses o_done.
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      dcnt8++;
      if (q8.size() == 0) chk(1'b0, $sformatf("w8_unexpected_done res=%0h expected none", r8));
      else begin
        e = q8.pop_front();
        cmp(e.nm, 16'(r8), e.res, c8, e.cy, v8, e.ov);
      end
    end
  end
  always @(negedge clk) begin
    if (done2) begin
      exp_t e;
      if (q2.size() == 0) chk(1'b0, $sformatf("w2_unexpected_done res=%0h expected none", r2));
      else begin
        e = q2.pop_front();
        cmp(e.nm, 16'(r2), e.res, c2, e.cy, v2, e.ov);
      end
    end
  end
  always @(negedge clk) begin
    if (done16) begin
      exp_t e;
      if (q16.size() == 0) chk(1'b0, $sformatf("w16_unexpected_done res=%0h expected none", r16));
      else begin
        e = q16.pop_front();
        cmp(e.nm, r16, e.res, c16, e.cy, v16, e.ov);
      end
    end
  end

  task automatic wait_done(input int w, output int c);
    int t;
    t = 0;
    while (!((w == 2) ? done2 : (w == 8) ? done8 : done16) && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!((w == 2) ? done2 : (w == 8) ? done8 : done16))
      chk(1'b0, $sformatf("w%0d_timeout done=0 required done=1", w));
    c = cyc;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     input logic [7:0] er, input logic ec, input logic eo, input string nm);
    exp_t e;
    int   nb, t;
    e.res = 16'(er); e.cy = ec; e.ov = eo; e.nm = nm;
    q8.push_back(e);
    @(negedge clk); a8 = a; b8 = b; m8 = m; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    chk(r8 === 8'h0 && c8 === 1'b0 && v8 === 1'b0,
        $sformatf("%s_clear res=%0h cy=%0b ov=%0b required 0/0/0", nm, r8, c8, v8));
    nb = 0; t = 0;
    while (!done8 && t < 40) begin
      if (busy8) nb++;
      @(negedge clk);
      t++;
    end
    chk(done8 === 1'b1 && t == 8 && nb == 8,
        $sformatf("%s_timing done=%0b latency=%0d busy=%0d required 1/8/8", nm, done8, t, nb));
    @(negedge clk);
    chk(!busy8 && !done8 && r8 === er && c8 === ec && v8 === eo,
        $sformatf("%s_hold busy=%0b done=%0b res=%0h required 0/0/%0h", nm, busy8, done8, r8, er));
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic m);
    int c;
    q2.push_back(model(2, 16'(a), 16'(b), m, $sformatf("w2 %0d%s%0d", a, m ? "-" : "+", b)));
    @(negedge clk); a2 = a; b2 = b; m2 = m; s2 = 1'b1;
    @(negedge clk); s2 = 1'b0;
    wait_done(2, c);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m);
    int c;
    q16.push_back(model(16, a, b, m, $sformatf("w16 %0h%s%0h", a, m ? "-" : "+", b)));
    @(negedge clk); a16 = a; b16 = b; m16 = m; s16 = 1'b1;
    @(negedge clk); s16 = 1'b0;
    wait_done(16, c);
  endtask

  initial begin
    int dc, t1, t2, t3;
    exp_t e;

    repeat (3) @(negedge clk);
    chk(!busy8 && !done8 && r8 === 8'h0 && c8 === 1'b0 && v8 === 1'b0 && r16 === 16'h0 && r2 === 2'h0,
        $sformatf("reset_state busy=%0b done=%0b res=%0h cy=%0b ov=%0b required all 0", busy8, done8, r8, c8, v8));
    rst = 1'b0;

    // Hand-computed WIDTH=8 vectors.
    op8(8'd100, 8'd27,  1'b0, 8'd127,  1'b0, 1'b0, "add_100_27");
    op8(8'd200, 8'd100, 1'b0, 8'd44,   1'b1, 1'b0, "add_200_100");
    op8(8'd100, 8'd100, 1'b0, 8'd200,  1'b0, 1'b1, "add_100_100");
    op8(8'd5,   8'd7,   1'b1, 8'd254,  1'b0, 1'b0, "sub_5_7");
    op8(8'd7,   8'd5,   1'b1, 8'd2,    1'b1, 1'b0, "sub_7_5");
    op8(8'h80,  8'h01,  1'b1, 8'h7F,   1'b1, 1'b1, "sub_80_1");
    op8(8'hFF,  8'h01,  1'b0, 8'h00,   1'b1, 1'b0, "add_ff_1");
    op8(8'h7F,  8'h01,  1'b0, 8'h80,   1'b0, 1'b1, "add_7f_1");
    op8(8'h80,  8'h80,  1'b0, 8'h00,   1'b1, 1'b1, "add_80_80");
    op8(8'h00,  8'h00,  1'b1, 8'h00,   1'b1, 1'b0, "sub_0_0");
    op8(8'h00,  8'h01,  1'b1, 8'hFF,   1'b0, 1'b0, "sub_0_1");

    // New start mid-RUN must be ignored.
    dc = dcnt8;
    e.res = 16'd30; e.cy = 1'b0; e.ov = 1'b0; e.nm = "ignore_midrun";
    q8.push_back(e);
    @(negedge clk); a8 = 8'd10; b8 = 8'd20; m8 = 1'b0; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd99; b8 = 8'd1; m8 = 1'b1; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    wait_done(8, t1);
    repeat (12) @(negedge clk);
    chk(dcnt8 - dc == 1, $sformatf("ignore_midrun done_pulses=%0d required 1", dcnt8 - dc));

    // Reset after three bits: everything cleared, operation dropped.
    dc = dcnt8;
    @(negedge clk); a8 = 8'd100; b8 = 8'd27; m8 = 1'b0; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(!busy8 && !done8 && r8 === 8'h0 && c8 === 1'b0 && v8 === 1'b0,
        $sformatf("reset_midrun busy=%0b done=%0b res=%0h cy=%0b ov=%0b required all 0", busy8, done8, r8, c8, v8));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk(dcnt8 == dc && !busy8, $sformatf("reset_midrun_nodone pulses=%0d busy=%0b required 0/0", dcnt8 - dc, busy8));

    // Reset and start together: reset wins.
    @(negedge clk); rst = 1'b1; a8 = 8'd3; b8 = 8'd4; m8 = 1'b0; s8 = 1'b1;
    @(negedge clk); rst = 1'b0; s8 = 1'b0;
    chk(!busy8 && !done8, $sformatf("reset_with_start busy=%0b done=%0b required 0/0", busy8, done8));
    @(negedge clk);
    chk(!busy8, $sformatf("reset_with_start_idle busy=%0b required 0", busy8));

    // Back-to-back with start held high.
    e.res = 16'd51;  e.cy = 1'b0; e.ov = 1'b0; e.nm = "b2b_17_34";  q8.push_back(e);
    e.res = 16'd240; e.cy = 1'b1; e.ov = 1'b0; e.nm = "b2b_250_10"; q8.push_back(e);
    e.res = 16'd254; e.cy = 1'b0; e.ov = 1'b1; e.nm = "b2b_7f_7f";  q8.push_back(e);
    @(negedge clk); a8 = 8'd17; b8 = 8'd34; m8 = 1'b0; s8 = 1'b1;
    @(negedge clk); a8 = 8'd250; b8 = 8'd10; m8 = 1'b1;
    wait_done(8, t1);
    @(negedge clk); a8 = 8'h7F; b8 = 8'h7F; m8 = 1'b0;
    wait_done(8, t2);
    @(negedge clk); s8 = 1'b0;
    wait_done(8, t3);
    chk(t2 - t1 == 9 && t3 - t2 == 9,
        $sformatf("b2b_spacing gaps=%0d,%0d required 9,9", t2 - t1, t3 - t2));
    @(negedge clk);
    chk(!busy8 && !done8, $sformatf("b2b_end busy=%0b done=%0b required 0/0", busy8, done8));

    // WIDTH=2 exhaustive.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int m = 0; m < 2; m++)
          op2(2'(a), 2'(b), 1'(m));

    // WIDTH=16 boundaries then random.
    op16(16'h8000, 16'h0001, 1'b1);
    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0);
    op16(16'h0000, 16'hFFFF, 1'b1);
    op16(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 30; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    chk(q8.size() == 0 && q2.size() == 0 && q16.size() == 0,
        $sformatf("scoreboard_drained pending=%0d/%0d/%0d required 0/0/0", q8.size(), q2.size(), q16.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
